// File: rtl/i2s_rx.sv
// I2S receiver: deserialises MSB-first left/right words into a one-deep stereo output register.
// Optional macro I2S_RX_SYNC_EN adds a two-flop synchroniser per serial input. WIDTH must be >= 2.
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             lrck,
    input  logic             sdin,
    output logic [WIDTH-1:0] sample_l,
    output logic [WIDTH-1:0] sample_r,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    // Serial inputs packed as {sck, lrck, sdin}
    logic [2:0] in_q;

`ifdef I2S_RX_SYNC_EN
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            in_q   <= '0;
        end else begin
            meta_q <= {sck, lrck, sdin};
            sync_q <= meta_q;
            in_q   <= sync_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
        end else begin
            in_q <= {sck, lrck, sdin};
        end
    end
`endif

    logic             sck_hist_q;
    logic             sck_rise;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic             lrck_cap_q, lrck_cap_d;
    logic             lrck_d_q, lrck_d_d;
    logic             pair_q, pair_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] sample_l_q, sample_l_d;
    logic [WIDTH-1:0] sample_r_q, sample_r_d;
    logic             boundary;
    logic             start;
    logic             accum;

    assign sck_rise = in_q[2] & ~sck_hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_hist_q  <= 1'b0;
            state_q     <= HUNT;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            lrck_cap_q  <= 1'b0;
            lrck_d_q    <= 1'b0;
            pair_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            valid_q     <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
        end else begin
            sck_hist_q  <= in_q[2];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            lrck_cap_q  <= lrck_cap_d;
            lrck_d_q    <= lrck_d_d;
            pair_q      <= pair_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            valid_q     <= valid_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
        end
    end

    // Receive FSM: lrck_cap_q is lrck from the previous event, giving the one-bit I2S delay
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        lrck_cap_d  = lrck_cap_q;
        lrck_d_d    = lrck_d_q;
        pair_d      = 1'b0;
        frame_err_d = 1'b0;
        boundary    = 1'b0;
        start       = 1'b0;
        accum       = 1'b0;
        if (sck_rise) begin
            lrck_cap_d = in_q[1];
            lrck_d_d   = lrck_cap_q;
            boundary   = (lrck_cap_q != lrck_d_q);
            case (state_q)
                HUNT: begin
                    if (boundary && !lrck_cap_q) begin
                        state_d = LEFT;
                        start   = 1'b1;
                    end
                end
                LEFT, RIGHT: begin
                    if (boundary) begin
                        if (cnt_q == FULL) begin
                            state_d = (state_q == LEFT) ? RIGHT : LEFT;
                            start   = 1'b1;
                        end else begin
                            state_d     = HUNT;
                            cnt_d       = '0;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        accum = (cnt_q < FULL);
                    end
                end
                default: state_d = HUNT;
            endcase
            if (start) begin
                shift_d = {shift_q[WIDTH-2:0], in_q[0]};
                cnt_d   = CW'(1);
            end else if (accum) begin
                shift_d = {shift_q[WIDTH-2:0], in_q[0]};
                cnt_d   = cnt_q + CW'(1);
            end
            if ((start || accum) && cnt_d == FULL) begin
                if (state_d == LEFT) begin
                    left_hold_d = shift_d;
                end else if (state_d == RIGHT) begin
                    pair_d = 1'b1;
                end
            end
        end
    end

    // Output stage; the right word still sits in shift_q one cycle after completion
    always_comb begin
        valid_d    = valid_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        overrun_d  = 1'b0;
        if (pair_q) begin
            if (!valid_q || ready) begin
                sample_l_d = left_hold_q;
                sample_r_d = shift_q;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign sample_l  = sample_l_q;
    assign sample_r  = sample_r_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Serial audio receiver, the capture-side counterpart of the synthesiser's I2S output path. It takes an external bit clock (`sck`), word-select (`lrck`) and serial data (`sdin`), deserialises MSB-first two's-complement words, and presents each completed left/right pair as a parallel stereo sample with a valid/ready handshake. It runs entirely on the system `clk`. The serial inputs are treated as data: they are sampled, and their edges are detected in the `clk` domain.

## Interface
- `WIDTH`, default 16: bits per channel word; also the width of each output sample.
- `clk`, input, 1: system clock. Must run at ≥ 4× `sck` frequency.
- `rst`, input, 1: synchronous, active-high reset.
- `sck`, input, 1: serial bit clock. `sdin` and `lrck` are sampled on its rising edge.
- `lrck`, input, 1: word select. 0 = left, 1 = right.
- `sdin`, input, 1: serial data, MSB first.
- `sample_l`, output, WIDTH: left word of the held pair.
- `sample_r`, output, WIDTH: right word of the held pair.
- `valid`, output, 1: a pair is held on `sample_l`/`sample_r`.
- `ready`, input, 1: consumer accepts the pair when `valid && ready`.
- `overrun`, output, 1: one-cycle pulse. A new pair was dropped because the held pair was not yet consumed.
- `frame_err`, output, 1: one-cycle pulse. A channel word was shorter than WIDTH bits.

## Operation
- **Input stage**
  - `sck`, `lrck` and `sdin` pass through the input stage (see Configuration).
  - One history flop on `sck` produces `sck_rise`, a single-cycle strobe.
- **Per `sck_rise` event** (all other cycles hold state)
  - `lrck_d` is the `lrck` captured at the previous event. This gives the standard I2S one-bit delay: the bit sampled at the event where `lrck` toggles still belongs to the previous channel.
  - A boundary occurs when the new `lrck_d` differs from its prior value.
- **Bit counting**
  - A counter of width clog2(WIDTH+1) counts bits in the current channel; it saturates at WIDTH.
  - Bits are shifted into a shift register while count < WIDTH.
  - Bits beyond WIDTH are ignored (truncation).
- **State machine** (states HUNT, LEFT, RIGHT; reset → HUNT)
  - HUNT: shift nothing. On a boundary with `lrck_d` 1→0, go to LEFT with count=0 and shift in the current bit.
  - LEFT: on reaching count=WIDTH, copy the shift register to `left_hold`. On boundary 0→1, go to RIGHT and clear count. If count<WIDTH at that boundary, pulse `frame_err` and go to HUNT instead.
  - RIGHT: on reaching count=WIDTH, the pair {`left_hold`, right word} is complete and is offered to the output stage. On boundary 1→0, go to LEFT. If count<WIDTH at that boundary, pulse `frame_err` and go to HUNT.
- **Output stage**
  - One-deep holding register.
  - Pair complete and (`!valid` or `ready`): load `sample_l`/`sample_r` and set `valid`=1.
  - Pair complete with `valid && !ready`: drop the new pair, keep the held pair, pulse `overrun`.
  - `valid && ready` with no new pair: clear `valid`. With a new pair in the same cycle, load the new pair and `valid` stays 1.
- Outputs never change while `valid && !ready`.

## Timing
- **Reset values:** `sample_l`=0, `sample_r`=0, `valid`=0, `overrun`=0, `frame_err`=0. Internally: state HUNT, count 0, shift register 0, `left_hold` 0, input history flops 0.
- Reset mid-word discards the partial word and the held pair. Reception resumes only after the next `lrck_d` 1→0 boundary.
- **Latency:** `valid` rises exactly L `clk` cycles after the `clk` edge that first registers the rising `sck` carrying the right word's LSB (input-stage flop 1).
  - L=4 with sync enabled; L=2 without.
- `frame_err` and `overrun` are asserted for exactly one `clk` cycle. They are registered and aligned with the cycle in which the event is resolved.
- `ready` is sampled combinationally with the pair-complete strobe on the same `clk` edge. No bubble is inserted between back-to-back pairs.
- `sck` high and low phases must each span ≥ 2 `clk` cycles. Behaviour is undefined otherwise.

## Configuration
- `I2S_RX_SYNC_EN` defined:
  - `sck`, `lrck` and `sdin` each pass through a two-flop synchroniser before edge detection.
  - Required when `sck` is sourced off-chip. L=4.
- `I2S_RX_SYNC_EN` undefined:
  - Each input is registered once.
  - Valid only when `sck` is generated from `clk` on-chip (e.g. the loopback from the transmit path). L=2.

## Test plan
- Reset, then frames of 16-bit words with left=16'hF00C, right=16'h1234, 8 `clk` per `sck`, `ready`=1 → first full frame after a 1→0 boundary yields `sample_l`=F00C, `sample_r`=1234, and `valid` high for one cycle L cycles after the right LSB.
- Same stream with `ready`=0 for two frames → first pair held. The second frame pulses `overrun` once and the outputs stay F00C/1234. Raising `ready` clears `valid`.
- 24 bits per channel, left=24'h8001FF, right=24'h7FFE00 → truncation yields `sample_l`=8001 and `sample_r`=7FFE, with no `frame_err`.
- A 10-bit left word between boundaries → `frame_err` pulses once at the 0→1 boundary, no pair is produced, and the next complete frame is received normally.
- Assert `rst` mid-right-word while `valid`=1 → all outputs 0 on the next cycle. The first pair appears only after the next left-start boundary.
- `ready` asserted in the same cycle a new pair completes → new pair is loaded, `valid` stays 1, and there is no `overrun`.
